// File: rtl/audioio_pkg.sv
// Shared register map, bit positions and reset defaults for the audioio block.
// Optional sigma-delta output stage is selected with AUDIOIO_SIGMADELTA_EN.
package audioio_pkg;

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_STATUS = 3'd1,
        REG_DATA   = 3'd2,
        REG_DIVHI  = 3'd3,
        REG_DIVLO  = 3'd4,
        REG_LEVEL  = 3'd5
    } reg_addr_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_FLUSH = 3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_LOW   = 2;
    localparam int ST_OVF   = 6;
    localparam int ST_UDR   = 7;

    localparam logic [15:0] DEF_RST_DIV = 16'd999;
    localparam logic [7:0]  RD_UNMAPPED = 8'hFF;

endpackage

// File: rtl/audioio_fifo.sv
// Sample FIFO: power-of-two depth, pointers wrap naturally, flush empties in one cycle.
module audioio_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    dout
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/audioio.sv
// CPU-mapped audio output: sample FIFO, rate divider, PWM (or sigma-delta when
// AUDIOIO_SIGMADELTA_EN is defined) modulator driving two identical audio pins.
module audioio
    import audioio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] RST_DIV    = DEF_RST_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    output logic [1:0] audio
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          en_q, en_d, irqen_q, irqen_d;
    logic          ovf_q, ovf_d, udr_q, udr_d;
    logic          irq_q, irq_d, aud_q, aud_d;
    logic [7:0]    divhi_q, divhi_d, divlo_q, divlo_d, sample_q, sample_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic          wr, wr_ctrl, wr_status, wr_data, wr_divhi, wr_divlo;
    logic          tick, flush, pop_req, popped, low;
    logic          f_full, f_empty;
    logic [CW-1:0] f_count;
    logic [7:0]    f_dout;

    assign wr        = cs && !rw;
    assign wr_ctrl   = wr && (AD == REG_CTRL);
    assign wr_status = wr && (AD == REG_STATUS);
    assign wr_data   = wr && (AD == REG_DATA);
    assign wr_divhi  = wr && (AD == REG_DIVHI);
    assign wr_divlo  = wr && (AD == REG_DIVLO);

    assign tick    = (tcnt_q == '0);
    assign flush   = wr_ctrl && DI[CTRL_FLUSH];
    assign pop_req = tick && en_q && !flush;
    assign popped  = pop_req && !f_empty;
    assign low     = (f_count <= CW'(FIFO_DEPTH / 2));

    audioio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (pop_req),
        .flush (flush),
        .din   (DI),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count),
        .dout  (f_dout)
    );

    always_comb begin
        en_d    = en_q;
        irqen_d = irqen_q;
        divhi_d = divhi_q;
        divlo_d = divlo_q;
        if (wr_ctrl) begin
            en_d    = DI[CTRL_EN];
            irqen_d = DI[CTRL_IRQEN];
        end
        if (wr_divhi) divhi_d = DI;
        if (wr_divlo) divlo_d = DI;
        // DIVLO restarts the period at once; DIVHI alone waits for the next reload.
        if (wr_divlo)  tcnt_d = {divhi_q, DI};
        else if (tick) tcnt_d = {divhi_q, divlo_q};
        else           tcnt_d = tcnt_q - 16'd1;
        sample_d = popped ? f_dout : sample_q;
        ovf_d    = (wr_data && f_full && !popped) || (ovf_q && !(wr_status && DI[ST_OVF]));
        udr_d    = (tick && en_q && f_empty) || (udr_q && !(wr_status && DI[ST_UDR]));
        irq_d    = en_q && irqen_q && (low || udr_q);
    end

`ifdef AUDIOIO_SIGMADELTA_EN
    logic [8:0] acc_q, acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[7:0]} + {1'b0, sample_q};
        aud_d = en_q && acc_q[8];
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
`else
    logic [7:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q + 8'd1;
        aud_d = en_q && (pwm_q < sample_q);
    end

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            irqen_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
            irq_q    <= 1'b0;
            aud_q    <= 1'b0;
            divhi_q  <= RST_DIV[15:8];
            divlo_q  <= RST_DIV[7:0];
            tcnt_q   <= RST_DIV;
            sample_q <= '0;
        end else begin
            en_q     <= en_d;
            irqen_q  <= irqen_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
            irq_q    <= irq_d;
            aud_q    <= aud_d;
            divhi_q  <= divhi_d;
            divlo_q  <= divlo_d;
            tcnt_q   <= tcnt_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        DO = RD_UNMAPPED;
        case (AD)
            REG_CTRL:   DO = {6'b0, irqen_q, en_q};
            REG_STATUS: begin
                DO           = '0;
                DO[ST_EMPTY] = f_empty;
                DO[ST_FULL]  = f_full;
                DO[ST_LOW]   = low;
                DO[ST_OVF]   = ovf_q;
                DO[ST_UDR]   = udr_q;
            end
            REG_DATA:   DO = 8'h00;
            REG_DIVHI:  DO = divhi_q;
            REG_DIVLO:  DO = divlo_q;
            REG_LEVEL:  DO = 8'(f_count);
            default:    DO = RD_UNMAPPED;
        endcase
    end

    assign irq   = irq_q;
    assign audio = {aud_q, aud_q};

endmodule

// File: tb/tb_audioio.sv
// Bench for audioio: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized bus traffic.
module tb_audioio;
    localparam int          DEPTH   = 16;
    localparam logic [15:0] RST_DIV = 16'd999;

    logic       clk, rst, rw, cs, irq;
    logic [2:0] AD;
    logic [7:0] DI, DO;
    logic [1:0] audio;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    audioio #(.FIFO_DEPTH(DEPTH), .RST_DIV(RST_DIV)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
        .rw(rw), .cs(cs), .irq(irq), .audio(audio)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned mq[$];
    int       m_cnt, m_cyc, m_acc, m_reload, m_sz;
    bit [7:0] m_hi, m_lo, m_sample;
    bit       m_en, m_irqen, m_ovf, m_udr, m_irq, m_aud;
    bit       m_wr, m_tick, m_flush, m_popped, m_ovf_set, m_udr_set;

    function automatic int model_rd(input logic [2:0] a);
        int s = mq.size();
        case (a)
            3'd0: return {m_irqen, m_en};
            3'd1: return (m_udr << 7) | (m_ovf << 6) | ((s <= DEPTH / 2) << 2)
                         | ((s == DEPTH) << 1) | (s == 0);
            3'd3: return m_hi;
            3'd4: return m_lo;
            3'd5: return s;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_cnt = RST_DIV; m_hi = 8'(RST_DIV >> 8); m_lo = 8'(RST_DIV);
            m_cyc = 0; m_acc = 0; m_sample = 0;
            m_en = 0; m_irqen = 0; m_ovf = 0; m_udr = 0; m_irq = 0; m_aud = 0;
        end else begin
            m_sz      = mq.size();
            m_wr      = cs && !rw;
            m_tick    = (m_cnt == 0);
            m_flush   = m_wr && AD == 3'd0 && DI[3];
            m_popped  = 0;
            m_ovf_set = 0;
            m_udr_set = 0;
            m_reload  = m_hi * 256 + m_lo;
`ifdef AUDIOIO_SIGMADELTA_EN
            m_aud = m_en && (m_acc >= 256);
            m_acc = (m_acc % 256) + m_sample;
`else
            m_aud = m_en && ((m_cyc % 256) < m_sample);
`endif
            m_irq = m_en && m_irqen && (m_sz <= DEPTH / 2 || m_udr);
            if (m_tick && m_en) begin
                if (m_sz == 0) m_udr_set = 1;
                else if (!m_flush) begin m_sample = mq.pop_front(); m_popped = 1; end
            end
            if (m_wr) begin
                case (AD)
                    3'd0: begin m_en = DI[0]; m_irqen = DI[1]; if (DI[3]) mq.delete(); end
                    3'd1: begin if (DI[6]) m_ovf = 0; if (DI[7]) m_udr = 0; end
                    3'd2: if (m_sz < DEPTH || m_popped) mq.push_back(DI); else m_ovf_set = 1;
                    3'd3: m_hi = DI;
                    3'd4: m_lo = DI;
                    default: ;
                endcase
            end
            if (m_wr && AD == 3'd4) m_cnt = m_hi * 256 + DI;
            else if (m_tick)        m_cnt = m_reload;
            else                    m_cnt = m_cnt - 1;
            if (m_udr_set) m_udr = 1;
            if (m_ovf_set) m_ovf = 1;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("irq", irq, m_irq);
            check("audio", audio, {m_aud, m_aud});
            if (AD != 3'd2) check("DO", DO, model_rd(AD));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        AD = a; DI = d; cs = 1; rw = 0;
        @(posedge clk); #1;
        cs = 0; rw = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input int e);
        AD = a;
        @(negedge clk); #1;
        check(nm, DO, e);
        @(posedge clk); #1;
    endtask

    task automatic duty(input string nm, input int e);
        int ones = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            ones += audio[0];
        end
        check(nm, ones, e);
        @(posedge clk); #1;
    endtask

    logic [2:0] ra;
    logic [7:0] rd;

    initial begin
        rst = 1; cs = 0; rw = 1; AD = 0; DI = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0; chk_en = 1;

        // reset state
        rd_chk("rst_status", 3'd1, 8'h05);
        rd_chk("rst_divhi", 3'd3, 8'h03);
        rd_chk("rst_divlo", 3'd4, 8'hE7);
        rd_chk("rst_level", 3'd5, 0);
        rd_chk("rst_unmapped", 3'd6, 8'hFF);
        check("rst_irq", irq, 0);
        check("rst_audio", audio, 0);

        // DIV=3, one sample 0x80, then 0x40
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd4, 8'h03);
        bus_wr(3'd2, 8'h80);
        bus_wr(3'd0, 8'h01);
        idle(2);
        rd_chk("play_level", 3'd5, 0);
        idle(2);
        duty("duty_80", 128);
        bus_wr(3'd2, 8'h40);
        idle(8);
        duty("duty_40", 64);
        bus_wr(3'd0, 8'h00);
        idle(2);
        check("en0_audio", audio, 0);

        // overflow with EN=0
        bus_wr(3'd1, 8'hC0);
        for (int i = 0; i < 17; i++) bus_wr(3'd2, 8'(10 + i));
        rd_chk("ovf_level", 3'd5, 16);
        rd_chk("ovf_status", 3'd1, 8'h42);
        bus_wr(3'd1, 8'h40);
        rd_chk("ovf_clr", 3'd1, 8'h02);

        // push into full FIFO coinciding with a tick pop
        bus_wr(3'd4, 8'h03);
        bus_wr(3'd0, 8'h01);
        idle(2);
        bus_wr(3'd2, 8'd200);
        bus_wr(3'd0, 8'h00);
        rd_chk("full_pp_level", 3'd5, 16);
        rd_chk("full_pp_status", 3'd1, 8'h02);
        bus_wr(3'd4, 8'h00);
        bus_wr(3'd0, 8'h01);
        idle(26);
        duty("tail_byte", 200);
        bus_wr(3'd0, 8'h00);

        // underrun interrupt, then clear with 9 queued
        bus_wr(3'd1, 8'hC0);
        bus_wr(3'd0, 8'h03);
        idle(1);
        rd_chk("udr_status", 3'd1, 8'h85);
        check("udr_irq", irq, 1);
        bus_wr(3'd3, 8'hFF);
        bus_wr(3'd4, 8'hFF);
        for (int i = 0; i < 9; i++) bus_wr(3'd2, 8'(i + 1));
        bus_wr(3'd1, 8'h80);
        idle(1);
        check("udr_clr_irq", irq, 0);
        rd_chk("udr_clr_status", 3'd1, 8'h00);

        // flush on a tick, then reset mid-playback
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd4, 8'h03);
        idle(3);
        bus_wr(3'd0, 8'h0B);
        rd_chk("flush_level", 3'd5, 0);
        for (int i = 0; i < 5; i++) bus_wr(3'd2, 8'hC0);
        idle(6);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_mid_audio", audio, 0);
        check("rst_mid_irq", irq, 0);
        rd_chk("rst_mid_level", 3'd5, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 199);
            if (r == 0) begin
                rst = 1; @(posedge clk); #1; rst = 0;
            end else if (r < 90) begin
                ra = 3'($urandom_range(0, 7));
                rd = 8'($urandom);
                if (ra == 3'd0 && $urandom_range(0, 7) != 0) rd[3] = 1'b0;
                if (ra == 3'd3) rd = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
                if (ra == 3'd4) rd = 8'($urandom_range(0, 9));
                bus_wr(ra, rd);
            end else begin
                AD = 3'($urandom_range(0, 7));
                cs = 1'($urandom); rw = 1;
                @(posedge clk); #1;
                cs = 0;
            end
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audioio.md
AUDIOIO -- requirements
Module: audioio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning sample FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter RST_DIV, default 16'd999, meaning reset value of the sample-rate divider.
REQ-003 SHALL have port clk, input, 1, the single system clock (sys_clk domain).
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port AD, input, 3, register select.
REQ-006 SHALL have port DI, input, 8, CPU write data.
REQ-007 SHALL have port DO, output, 8, register read data.
REQ-008 SHALL have port rw, input, 1, 1=read, 0=write.
REQ-009 SHALL have port cs, input, 1, chip select (decode && vma).
REQ-010 SHALL have port irq, output, 1, level interrupt request.
REQ-011 SHALL have port audio, output, 2, modulated audio pins.

Function
REQ-012 SHALL implement a bus write as cs && !rw sampled at posedge clk; reads SHALL be combinational from AD with no side effects.
REQ-013 SHALL map registers as follows: 0 CTRL R/W (b0 EN, b1 IRQEN, b3 FLUSH, write-only, reads 0); 1 STATUS R (b0 EMPTY, b1 FULL, b2 LOW, b6 OVF, b7 UDR); 2 DATA W (FIFO push); 3 DIVHI R/W; 4 DIVLO R/W; 5 LEVEL R (FIFO count); 6-7 read 8'hFF.
REQ-014 SHALL clear OVF and UDR when STATUS is written with 1 in the corresponding bit, per bit.
REQ-015 SHALL decrement a 16-bit tick counter each clk, reload it with {DIVHI,DIVLO} at zero, and assert a one-cycle tick on reload, giving a period of DIV+1 clk cycles.
REQ-016 SHALL reload the tick counter immediately on a DIVLO write; a DIVHI write SHALL take effect at the next reload.
REQ-017 SHALL, on tick with EN=1, pop the FIFO head into the 8-bit sample register when non-empty, and otherwise hold the sample and set UDR.
REQ-018 SHALL push DATA into the FIFO on write; a push when full SHALL be discarded and SHALL set OVF, unless a pop occurs in the same cycle, in which case both take effect and the count is unchanged.
REQ-019 SHALL handle push and pop in the same cycle on an empty FIFO as follows: the push is accepted, the pop is treated as underrun (UDR set), and the count becomes 1.
REQ-020 SHALL, on FLUSH, empty the FIFO in that cycle, overriding a same-cycle pop; the sample register is kept.
REQ-021 SHALL derive LOW as count <= FIFO_DEPTH/2.
REQ-022 SHALL drive irq = EN && IRQEN && (LOW || UDR), registered with 1 cycle latency.
REQ-023 SHALL, in PWM mode, compare an 8-bit free-running counter against the sample: audio[0] = (pwm_cnt < sample) registered, audio[1] = audio[0]; sample 0 SHALL give constant 0 and 255 SHALL give 255/256 duty.
REQ-024 SHALL, when EN=0, stop pops, hold audio at 2'b00, keep the tick counter running, and keep FIFO pushes accepted.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 SHALL, on rst, clear CTRL, the FIFO (EMPTY=1, LEVEL=0), OVF, UDR, sample, pwm_cnt, and the sigma-delta accumulator, load DIV=RST_DIV and the tick counter=RST_DIV, and drive irq=0 and audio=2'b00.
REQ-027 SHALL take rst priority over any same-cycle bus write; rst mid-playback SHALL discard all queued samples.

Configuration
REQ-028 SHALL, when AUDIOIO_SIGMADELTA_EN is defined, replace PWM with a first-order sigma-delta: a 9-bit accumulator acc <= acc[7:0] + sample each clk, audio[0] = acc[8] registered, audio[1] = audio[0]; EN=0 still forces 00.
REQ-029 SHALL, when AUDIOIO_SIGMADELTA_EN is undefined, use the PWM of REQ-023 with no accumulator logic present.

Structure
REQ-030 SHALL place register offsets, CTRL/STATUS bit positions, and the RST_DIV default in a shared package audioio_pkg.
REQ-031 SHALL implement the FIFO as sub-module audioio_fifo (push, pop, flush, full, empty, count, dout).

Verification
REQ-032 SHALL cover: reset, then read AD=1 -> 8'h05 (EMPTY|LOW), AD=3/4 -> RST_DIV bytes, irq=0, audio=00.
REQ-033 SHALL cover: DIV=3, push 8'h80, EN=1 -> sample=8'h80 on the next tick (<=4 cycles), then audio[0] high 128 of every 256 cycles in PWM mode.
REQ-034 SHALL cover: 17 pushes with EN=0, depth 16 -> LEVEL=16, FULL=1, OVF=1; write STATUS 8'h40 -> OVF=0.
REQ-035 SHALL cover: EN=1, IRQEN=1, empty FIFO, DIV=0 -> UDR=1 after the first tick, irq=1 one cycle later; write 8'h80 to STATUS with the FIFO filled to 9 -> irq=0.
REQ-036 SHALL cover: full FIFO, push coinciding with a tick pop -> LEVEL stays 16, OVF=0, new byte at tail.
REQ-037 SHALL cover: FLUSH with a same-cycle tick, then rst asserted mid-playback -> LEVEL=0, audio=00 next cycle; with AUDIOIO_SIGMADELTA_EN and sample 8'h40 -> 64 ones per 256 cycles.
